// File: rtl/mux_sel_sequencer_if.sv
// rtl/mux_sel_sequencer_if.sv - configuration, control and mux-drive signals of the step sequencer
interface mux_sel_sequencer_if #(
   parameter int SEL_W = 1,
   parameter int CNT_W = 16,
   parameter int IDX_W = 3
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [IDX_W-1:0] cfg_addr;
   logic [SEL_W-1:0] cfg_sel;
   logic [CNT_W-1:0] cfg_len;
   logic [IDX_W:0]   nsteps;
   logic             loop;
   logic             start;
   logic             abort;
   logic [SEL_W-1:0] sel;
   logic             run;
   logic             busy;
   logic             done;
   logic [IDX_W-1:0] step;

   modport master (
      output cfg_valid, cfg_addr, cfg_sel, cfg_len, nsteps, loop, start, abort,
      input  cfg_ready, sel, run, busy, done, step
   );

   modport slave (
      input  cfg_valid, cfg_addr, cfg_sel, cfg_len, nsteps, loop, start, abort,
      output cfg_ready, sel, run, busy, done, step
   );
endinterface

// File: rtl/mux_sel_sequencer.sv
// rtl/mux_sel_sequencer.sv - table-driven sequencer holding each mux select for a programmed cycle count
module mux_sel_sequencer #(
   parameter int SEL_W  = 1,
   parameter int CNT_W  = 16,
   parameter int NSTEPS = 8,
   parameter int IDX_W  = 3
) (
   input logic           clk,
   input logic           rst,
   mux_sel_sequencer_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [IDX_W:0] MAX_STEPS = (IDX_W+1)'(NSTEPS);

   state_t           state, state_nxt;
   logic [SEL_W-1:0] tbl_sel [NSTEPS];
   logic [CNT_W-1:0] tbl_len [NSTEPS];
   logic [IDX_W:0]   nsteps_q;
   logic [IDX_W:0]   nsteps_clamped;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] step_q;
   logic [IDX_W-1:0] idx_nxt;
   logic [SEL_W-1:0] sel_q;
   logic             run_q;
   logic             load;
   logic             last;
   logic             start_ok;

   assign nsteps_clamped = (bus.nsteps > MAX_STEPS) ? MAX_STEPS : bus.nsteps;
   assign last           = ({1'b0, step_q} == (nsteps_q - 1'b1));
   assign start_ok       = bus.start && !bus.abort;

   // load: the next edge enters table entry idx_nxt (first entry, next entry, or wrap)
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      idx_nxt   = step_q;
      case (state)
         S_IDLE: begin
            if (start_ok) begin
               if (nsteps_clamped != '0) begin
                  state_nxt = S_RUN;
                  load      = 1'b1;
                  idx_nxt   = '0;
               end else begin
                  state_nxt = S_DONE;
               end
            end
         end
         S_RUN: begin
            if (bus.abort) begin
               state_nxt = S_DONE;
            end else if (cnt == '0) begin
               if (last && !bus.loop) begin
                  state_nxt = S_DONE;
               end else begin
                  load    = 1'b1;
                  idx_nxt = last ? '0 : step_q + 1'b1;
               end
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         nsteps_q <= '0;
         cnt      <= '0;
         step_q   <= '0;
         sel_q    <= '0;
         run_q    <= 1'b0;
         for (int i = 0; i < NSTEPS; i++) begin
            tbl_sel[i] <= '0;
            tbl_len[i] <= '0;
         end
      end else begin
         state <= state_nxt;
         if (bus.cfg_valid && bus.cfg_ready) begin
            tbl_sel[bus.cfg_addr] <= bus.cfg_sel;
            tbl_len[bus.cfg_addr] <= bus.cfg_len;
         end
         if (state == S_IDLE && start_ok)
            nsteps_q <= nsteps_clamped;
         // a zero-length entry still takes one cycle: counter parks at 0 with run low
         if (load) begin
            step_q <= idx_nxt;
            sel_q  <= tbl_sel[idx_nxt];
            cnt    <= (tbl_len[idx_nxt] == '0) ? '0 : tbl_len[idx_nxt] - 1'b1;
            run_q  <= (tbl_len[idx_nxt] != '0);
         end else if (state == S_RUN && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (state_nxt != S_RUN)
            run_q <= 1'b0;
      end
   end

   assign bus.cfg_ready = (state != S_RUN);
   assign bus.busy      = (state == S_RUN);
   assign bus.done      = (state == S_DONE);
   assign bus.sel       = sel_q;
   assign bus.run       = run_q;
   assign bus.step      = step_q;
endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb/tb_mux_sel_sequencer.sv - scoreboard bench for mux_sel_sequencer
module tb_mux_sel_sequencer;
   localparam int SEL_W  = 1;
   localparam int CNT_W  = 16;
   localparam int NSTEPS = 8;
   localparam int IDX_W  = 3;

   typedef struct packed {
      logic [SEL_W-1:0] sel;
      logic             run;
      logic             busy;
      logic             done;
      logic [IDX_W-1:0] step;
      logic             chk_step;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t q[$];
   logic [SEL_W-1:0] tsel_m [NSTEPS];
   int               tlen_m [NSTEPS];
   logic [SEL_W-1:0] last_sel = '0;

   mux_sel_sequencer_if #(.SEL_W(SEL_W), .CNT_W(CNT_W), .IDX_W(IDX_W)) bus ();

   mux_sel_sequencer #(.SEL_W(SEL_W), .CNT_W(CNT_W), .NSTEPS(NSTEPS), .IDX_W(IDX_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic push(input logic [SEL_W-1:0] s, input logic r, input logic b, input logic d,
                       input int st, input logic c);
      exp_t e;
      e.sel = s; e.run = r; e.busy = b; e.done = d; e.step = IDX_W'(st); e.chk_step = c;
      q.push_back(e);
   endtask

   task automatic push_pass(input int n);
      for (int i = 0; i < n; i++) begin
         if (tlen_m[i] == 0) push(tsel_m[i], 1'b0, 1'b1, 1'b0, i, 1'b1);
         else for (int k = 0; k < tlen_m[i]; k++) push(tsel_m[i], 1'b1, 1'b1, 1'b0, i, 1'b1);
      end
   endtask

   task automatic push_tail(input logic [SEL_W-1:0] s);
      last_sel = s;
      push(s, 1'b0, 1'b0, 1'b1, 0, 1'b0);
      push(s, 1'b0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) push(last_sel, 1'b0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic cfg_write(input int a, input logic [SEL_W-1:0] s, input int l);
      @(posedge clk); #1;
      bus.cfg_valid = 1'b1; bus.cfg_addr = IDX_W'(a); bus.cfg_sel = s; bus.cfg_len = CNT_W'(l);
      @(posedge clk); #1;
      bus.cfg_valid = 1'b0;
      tsel_m[a] = s; tlen_m[a] = l;
   endtask

   task automatic start_seq(input int n, input logic lp);
      @(posedge clk); #1;
      bus.nsteps = (IDX_W+1)'(n); bus.loop = lp; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // act: 1 drop loop, 2 abort, 3 cfg write + start while busy; released one item later
   task automatic drain(input string name, input int act_idx, input int act);
      exp_t e;
      int   k = 0;
      while (q.size() > 0) begin
         @(negedge clk);
         e = q.pop_front();
         n_tests++;
         if ({bus.sel, bus.run, bus.busy, bus.done} !== {e.sel, e.run, e.busy, e.done} ||
             (e.chk_step && bus.step !== e.step)) begin
            n_fail++;
            $display("FAIL %s item %0d: got sel=%0d run=%0b busy=%0b done=%0b step=%0d, want sel=%0d run=%0b busy=%0b done=%0b step=%0d",
                     name, k, bus.sel, bus.run, bus.busy, bus.done, bus.step,
                     e.sel, e.run, e.busy, e.done, e.step);
         end
         if (k == act_idx) begin
            case (act)
               1: bus.loop = 1'b0;
               2: bus.abort = 1'b1;
               3: begin
                  n_tests++;
                  if (bus.cfg_ready !== 1'b0) begin
                     n_fail++;
                     $display("FAIL %s cfg_ready_busy: got %0b want 0", name, bus.cfg_ready);
                  end
                  bus.cfg_valid = 1'b1; bus.cfg_addr = 1; bus.cfg_sel = '0; bus.cfg_len = 7;
                  bus.start = 1'b1; bus.nsteps = 1;
               end
               default: ;
            endcase
         end
         if (k == act_idx + 1) begin
            bus.abort = 1'b0; bus.cfg_valid = 1'b0; bus.start = 1'b0;
         end
         k++;
      end
   endtask

   task automatic check_reset_values(input string name);
      n_tests++;
      if ({bus.sel, bus.run, bus.busy, bus.done, bus.step, bus.cfg_ready} !== {SEL_W'(0), 3'b000, IDX_W'(0), 1'b1}) begin
         n_fail++;
         $display("FAIL %s: got sel=%0d run=%0b busy=%0b done=%0b step=%0d cfg_ready=%0b, want 0 0 0 0 0 1",
                  name, bus.sel, bus.run, bus.busy, bus.done, bus.step, bus.cfg_ready);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_values("reset");
      for (int i = 0; i < NSTEPS; i++) begin tsel_m[i] = '0; tlen_m[i] = 0; end
      last_sel = '0;
   endtask

   task automatic test_basic();
      cfg_write(0, 1'b0, 3);
      cfg_write(1, 1'b1, 2);
      start_seq(2, 1'b0);
      push_pass(2); push_tail(tsel_m[1]);
      drain("basic", -2, 0);
   endtask

   task automatic test_zero_len();
      cfg_write(0, 1'b1, 0);
      cfg_write(1, 1'b0, 4);
      start_seq(2, 1'b0);
      push_pass(2); push_tail(tsel_m[1]);
      drain("zero_len", -2, 0);
   endtask

   task automatic test_loop();
      cfg_write(0, 1'b0, 1);
      cfg_write(1, 1'b1, 1);
      start_seq(2, 1'b1);
      push_pass(2); push_pass(2); push_pass(2); push_tail(tsel_m[1]);
      drain("loop", 4, 1);
   endtask

   task automatic test_abort();
      cfg_write(0, 1'b1, 10);
      start_seq(1, 1'b0);
      push(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1);
      push(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1);
      push_tail(1'b1);
      drain("abort", 1, 2);
   endtask

   task automatic test_busy_cfg();
      cfg_write(0, 1'b0, 3);
      cfg_write(1, 1'b1, 2);
      start_seq(2, 1'b0);
      push_pass(2); push_tail(tsel_m[1]);
      drain("busy_cfg", 1, 3);
      start_seq(2, 1'b0);
      push_pass(2); push_tail(tsel_m[1]);
      drain("table_unchanged", -2, 0);
      start_seq(0, 1'b0);
      push_tail(last_sel);
      drain("nsteps_zero", -2, 0);
   endtask

   task automatic test_clamp();
      for (int i = 0; i < NSTEPS; i++) cfg_write(i, SEL_W'(i % 2), i % 3);
      start_seq(15, 1'b0);
      push_pass(NSTEPS); push_tail(tsel_m[NSTEPS-1]);
      drain("clamp", -2, 0);
   endtask

   task automatic test_abort_start_idle();
      @(posedge clk); #1;
      bus.abort = 1'b1; bus.nsteps = 2; bus.loop = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0; bus.start = 1'b0;
      push_idle(3);
      drain("abort_start_idle", -2, 0);
   endtask

   task automatic test_reset_mid_run();
      cfg_write(0, 1'b1, 10);
      start_seq(1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_values("reset_mid_run");
      for (int i = 0; i < NSTEPS; i++) begin tsel_m[i] = '0; tlen_m[i] = 0; end
      start_seq(2, 1'b0);
      push_pass(2); push_tail(tsel_m[1]);
      drain("empty_table", -2, 0);
   endtask

   initial begin
      bus.cfg_valid = 1'b0; bus.cfg_addr = '0; bus.cfg_sel = '0; bus.cfg_len = '0;
      bus.nsteps = '0; bus.loop = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
      test_reset();
      test_basic();
      test_zero_len();
      test_loop();
      test_abort();
      test_busy_cfg();
      test_clamp();
      test_abort_start_idle();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end
endmodule
